// File: rtl/flag_consumer.sv
`default_nettype none
// ============================================================================
// Module   : flag_consumer
// Purpose  : Consumer end of the flag set/unset protocol. Accepts a request
//            naming a subset of producer-owned status flags and waits until
//            all of them are set. It then presents a go token downstream.
//            Once the token is taken, it pulses the matching unset lines for
//            one cycle so that exactly those flags are cleared. The wait is
//            bounded: if the flags do not arrive in time, the request is
//            aborted with a one-cycle timeout pulse.
//
// Ports    : clk        rising-edge clock
//            rst        asynchronous, active-low reset
//            req_valid  request to wait on a flag subset
//            req_mask   flags required (sampled on the request handshake)
//            req_ready  block can accept a request (IDLE)
//            flags_in   current flag values from the flag registers
//            unset_out  one-cycle unset pulses back to the flag registers
//            go_valid   required flags were observed set
//            go_ready   downstream accepts the go token
//            timeout    one-cycle pulse, request aborted
//            busy       high in any state other than IDLE
//
// Revision : 1.0  initial release
// ============================================================================
module flag_consumer #(
    parameter int NFLAGS  = 4,
    parameter int TIMEOUT = 200,   // 0 disables the bounded wait
    parameter int CNT_W   = 8      // 2**CNT_W must cover TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [NFLAGS-1:0] req_mask,
    output logic              req_ready,
    input  logic [NFLAGS-1:0] flags_in,
    output logic [NFLAGS-1:0] unset_out,
    output logic              go_valid,
    input  logic              go_ready,
    output logic              timeout,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2,
        CLR   = 2'd3
    } state_t;

    localparam bit               TIMEOUT_EN = (TIMEOUT != 0);
    // Last WAIT cycle index that may still look for the flags.
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((TIMEOUT != 0) ? (TIMEOUT - 1) : 0);

    state_t            state;
    logic [NFLAGS-1:0] mask;
    logic [CNT_W-1:0]  cnt;
    logic              sat;

    // An empty mask is trivially satisfied.
    assign sat = ((flags_in & mask) == mask);

    // All outputs are registered alongside the state. This keeps every
    // input-to-output path broken by a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mask      <= '0;
            cnt       <= '0;
            unset_out <= '0;
            go_valid  <= 1'b0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            // Pulse outputs default low and are raised only on their transition.
            unset_out <= '0;
            timeout   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        mask      <= req_mask;
                        cnt       <= '0;
                        state     <= WAIT;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                    end
                end
                WAIT: begin
                    // A satisfied wait wins over a same-cycle expiry.
                    if (sat) begin
                        state    <= ISSUE;
                        go_valid <= 1'b1;
                    end else if (TIMEOUT_EN && (cnt == CNT_LAST)) begin
                        state     <= IDLE;
                        timeout   <= 1'b1;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ISSUE: begin
                    // Flags are committed once seen; they are not re-checked here.
                    if (go_ready) begin
                        state     <= CLR;
                        go_valid  <= 1'b0;
                        unset_out <= mask;
                    end
                end
                CLR: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    go_valid  <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flag_consumer.sv
`default_nettype none
// ============================================================================
// Module   : tb_flag_consumer
// Purpose  : Self-checking bench for flag_consumer.
//            Instance "dut" uses the default TIMEOUT of 200.
//            Instance "dut_t" uses TIMEOUT=5 to exercise the bounded wait.
//            Each instance is driven by a small producer-side flag register,
//            in which unset wins over set.
//
//            Outputs are sampled on the falling edge. Inputs are driven on
//            the same falling edge, right after sampling.
//            Cycle c is the period whose outputs are seen at the c-th
//            sampled falling edge. A request driven in cycle 0 is accepted
//            at the following rising edge.
//
// Revision : 1.0  initial release
// ============================================================================
module tb_flag_consumer;
    localparam int NF    = 4;
    localparam int TB_TO = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // default-timeout instance
    logic          req_valid, req_ready, go_valid, go_ready, timeout, busy;
    logic [NF-1:0] req_mask, unset_out;
    logic [NF-1:0] set_pulse = '0;
    logic [NF-1:0] flags_in  = '0;
    logic          flag_clr  = 1'b0;

    // short-timeout instance
    logic          b_req_valid, b_req_ready, b_go_valid, b_go_ready, b_timeout, b_busy;
    logic [NF-1:0] b_req_mask, b_unset_out;
    logic [NF-1:0] b_set_pulse = '0;
    logic [NF-1:0] b_flags_in  = '0;
    logic          b_flag_clr  = 1'b0;

    int total = 0;
    int bad   = 0;

    flag_consumer #(.NFLAGS(NF), .TIMEOUT(200), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_mask(req_mask), .req_ready(req_ready),
        .flags_in(flags_in), .unset_out(unset_out),
        .go_valid(go_valid), .go_ready(go_ready),
        .timeout(timeout), .busy(busy)
    );

    flag_consumer #(.NFLAGS(NF), .TIMEOUT(TB_TO), .CNT_W(3)) dut_t (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_mask(b_req_mask), .req_ready(b_req_ready),
        .flags_in(b_flags_in), .unset_out(b_unset_out),
        .go_valid(b_go_valid), .go_ready(b_go_ready),
        .timeout(b_timeout), .busy(b_busy)
    );

    // Producer-owned flag registers: unset has priority over set.
    always @(posedge clk) begin
        flags_in   <= flag_clr   ? '0 : ((flags_in   | set_pulse)   & ~unset_out);
        b_flags_in <= b_flag_clr ? '0 : ((b_flags_in | b_set_pulse) & ~b_unset_out);
    end

    // Packed view: {req_ready, busy, go_valid, timeout, unset_out[3:0]}
    task automatic test_reset();
        logic [7:0] got;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        got = {req_ready, busy, go_valid, timeout, unset_out};
        total++;
        if (got !== 8'b1000_0000) begin
            bad++;
            $display("FAIL reset_held got=%b exp=%b", got, 8'b1000_0000);
        end
        rst = 1'b1;
        @(negedge clk);
        got = {req_ready, busy, go_valid, timeout, unset_out};
        total++;
        if (got !== 8'b1000_0000) begin
            bad++;
            $display("FAIL reset_idle got=%b exp=%b", got, 8'b1000_0000);
        end
        got = {b_req_ready, b_busy, b_go_valid, b_timeout, b_unset_out};
        total++;
        if (got !== 8'b1000_0000) begin
            bad++;
            $display("FAIL reset_idle_b got=%b exp=%b", got, 8'b1000_0000);
        end
    endtask

    // Flags already set at request time: go at 2, unset at 3, ready at 4.
    task automatic test_basic();
        logic [7:0] got, exp;
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr  = 1'b0;
        set_pulse = 4'b0011;
        @(negedge clk);
        set_pulse = '0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            got = {req_ready, busy, go_valid, timeout, unset_out};
            exp = {(c == 0 || c >= 4), (c >= 1 && c <= 3), (c == 2), 1'b0,
                   (c == 3) ? 4'b0011 : 4'b0000};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL basic cyc%0d got=%b exp=%b", c, got, exp);
            end
            req_valid = (c == 0);
            req_mask  = 4'b0011;
            go_ready  = 1'b1;
        end
        total++;
        if (flags_in !== 4'b0000) begin
            bad++;
            $display("FAIL basic_flags_cleared got=%b exp=%b", flags_in, 4'b0000);
        end
    endtask

    // Late flag, go held off by downstream, unmasked flag left alone.
    task automatic test_hold();
        logic [7:0] got, exp;
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr  = 1'b0;
        set_pulse = 4'b0001;
        @(negedge clk);
        set_pulse = '0;
        for (int c = 0; c < 19; c++) begin
            if (c > 0) @(negedge clk);
            got = {req_ready, busy, go_valid, timeout, unset_out};
            exp = {(c == 0 || c >= 17), (c >= 1 && c <= 16), (c >= 11 && c <= 15), 1'b0,
                   (c == 16) ? 4'b0101 : 4'b0000};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL hold cyc%0d got=%b exp=%b", c, got, exp);
            end
            req_valid = (c == 0);
            req_mask  = 4'b0101;
            set_pulse = (c == 9) ? 4'b0100 : ((c == 3) ? 4'b1000 : 4'b0000);
            go_ready  = (c == 15);
        end
        set_pulse = '0;
        total++;
        if (flags_in !== 4'b1000) begin
            bad++;
            $display("FAIL hold_unmasked_kept got=%b exp=%b", flags_in, 4'b1000);
        end
    endtask

    // TIMEOUT=5: abort 6 cycles after acceptance; then an empty-mask request.
    task automatic test_timeout();
        logic [7:0] got, exp;
        b_flag_clr = 1'b1;
        @(negedge clk);
        b_flag_clr = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            got = {b_req_ready, b_busy, b_go_valid, b_timeout, b_unset_out};
            exp = {(c == 0 || c == 6 || c == 7 || c >= 11),
                   ((c >= 1 && c <= 5) || (c >= 8 && c <= 10)),
                   (c == 9), (c == 6), 4'b0000};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL timeout cyc%0d got=%b exp=%b", c, got, exp);
            end
            b_req_valid = (c == 0 || c == 7);
            b_req_mask  = (c == 0) ? 4'b1000 : 4'b0000;
            b_go_ready  = 1'b1;
        end
        b_req_valid = 1'b0;
    endtask

    // Flag lands exactly on the last counted WAIT cycle: ISSUE, no timeout.
    task automatic test_race();
        logic [7:0] got, exp;
        b_flag_clr = 1'b1;
        @(negedge clk);
        b_flag_clr = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            got = {b_req_ready, b_busy, b_go_valid, b_timeout, b_unset_out};
            exp = {(c == 0 || c >= 8), (c >= 1 && c <= 7), (c == 6), 1'b0,
                   (c == 7) ? 4'b0010 : 4'b0000};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL race cyc%0d got=%b exp=%b", c, got, exp);
            end
            b_req_valid = (c == 0);
            b_req_mask  = 4'b0010;
            b_set_pulse = (c == 4) ? 4'b0010 : 4'b0000;
            b_go_ready  = 1'b1;
        end
        b_set_pulse = '0;
    endtask

    // Reset asserted mid-cycle while go_valid is up.
    task automatic test_async_reset();
        logic [7:0] got, exp;
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr  = 1'b0;
        set_pulse = 4'b0110;
        @(negedge clk);
        set_pulse = '0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            got = {req_ready, busy, go_valid, timeout, unset_out};
            exp = {(c == 0), (c >= 1), (c >= 2), 1'b0, 4'b0000};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL arst_pre cyc%0d got=%b exp=%b", c, got, exp);
            end
            req_valid = (c == 0);
            req_mask  = 4'b0110;
            go_ready  = 1'b0;
        end
        #2 rst = 1'b0;
        #1;
        got = {req_ready, busy, go_valid, timeout, unset_out};
        total++;
        if (got !== 8'b1000_0000) begin
            bad++;
            $display("FAIL arst_immediate got=%b exp=%b", got, 8'b1000_0000);
        end
        @(negedge clk);
        rst      = 1'b1;
        go_ready = 1'b1;
        @(negedge clk);
        got = {req_ready, busy, go_valid, timeout, unset_out};
        total++;
        if (got !== 8'b1000_0000) begin
            bad++;
            $display("FAIL arst_release got=%b exp=%b", got, 8'b1000_0000);
        end
        total++;
        if (flags_in !== 4'b0110) begin
            bad++;
            $display("FAIL arst_flags_kept got=%b exp=%b", flags_in, 4'b0110);
        end
    endtask

    // Random masks, preset flags, arrival times and go delays on the
    // TIMEOUT=5 instance.
    // Expected timeline:
    //   t   = first cycle >= 1 at which every masked flag is present.
    //   If t > TIMEOUT: abort pulse at TIMEOUT+1.
    //   Otherwise: go from t+1 until the handshake, unset one cycle later.
    task automatic test_random();
        logic [NF-1:0] mask, f0, sp;
        int            st[NF];
        int            tstar, gs, hs, last;
        bit            to, busy_e;
        logic [7:0]    got, exp;
        for (int t = 0; t < 40; t++) begin
            mask = NF'($urandom);
            f0   = NF'($urandom);
            for (int i = 0; i < NF; i++) st[i] = int'($urandom_range(1, 8));
            tstar = 1;
            for (int i = 0; i < NF; i++)
                if (mask[i] && !f0[i] && st[i] > tstar) tstar = st[i];
            to   = (tstar > TB_TO);
            gs   = tstar + 1;
            hs   = gs + int'($urandom_range(0, 3));
            last = to ? TB_TO + 3 : hs + 3;

            b_flag_clr = 1'b1;
            @(negedge clk);
            b_flag_clr  = 1'b0;
            b_set_pulse = f0;
            @(negedge clk);
            b_set_pulse = '0;
            for (int c = 0; c <= last; c++) begin
                if (c > 0) @(negedge clk);
                busy_e = to ? (c >= 1 && c <= TB_TO) : (c >= 1 && c <= hs + 1);
                got = {b_req_ready, b_busy, b_go_valid, b_timeout, b_unset_out};
                exp = {!busy_e, busy_e, (!to && c >= gs && c <= hs), (to && c == TB_TO + 1),
                       (!to && c == hs + 1) ? mask : 4'b0000};
                total++;
                if (got !== exp) begin
                    bad++;
                    $display("FAIL random txn%0d cyc%0d mask=%b got=%b exp=%b",
                             t, c, mask, got, exp);
                end
                sp = '0;
                for (int i = 0; i < NF; i++) if (!f0[i] && st[i] == c + 1) sp[i] = 1'b1;
                b_set_pulse = sp;
                b_req_valid = (c == 0);
                b_req_mask  = mask;
                b_go_ready  = (c == hs) || (c < gs && $urandom_range(0, 1) == 1);
            end
            b_set_pulse = '0;
            b_req_valid = 1'b0;
        end
    endtask

    initial begin
        rst         = 1'b0;
        req_valid   = 1'b0;
        req_mask    = '0;
        go_ready    = 1'b0;
        b_req_valid = 1'b0;
        b_req_mask  = '0;
        b_go_ready  = 1'b0;
        test_reset();
        test_basic();
        test_hold();
        test_timeout();
        test_race();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/flag_consumer.md
Name: flag_consumer

Overview:
- Consumer end of the flag set/unset protocol: waits until a requested subset of status flags is set, then hands a go token downstream and clears exactly those flags.
- Each flag bit comes from a set/unset flag register owned by a producer, e.g. "key loaded" or "nonce loaded" in the mode controller.
- Clearing is done by pulsing the matching per-flag unset line back to those registers.
- Includes a bounded wait with a timeout indication.

Parameters:
- NFLAGS, 4, number of flag inputs / unset outputs.
- TIMEOUT, 200, max WAIT cycles before abort; 0 disables timeout.
- CNT_W, 8, timeout counter width; must satisfy 2^CNT_W >= TIMEOUT.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-low.
- req_valid  input  1  request to wait on a flag subset.
- req_mask  input  NFLAGS  flags required; sampled on req handshake.
- req_ready  output  1  block can accept a request.
- flags_in  input  NFLAGS  current flag values from the flag registers.
- unset_out  output  NFLAGS  one-cycle unset pulses to the flag registers.
- go_valid  output  1  required flags observed set.
- go_ready  input  1  downstream accepts go.
- timeout  output  1  one-cycle pulse: request aborted.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.
- Reset (rst=0, async):
  - state=IDLE, mask register=0, counter=0.
  - unset_out=0, go_valid=0, timeout=0, busy=0, req_ready=1.
- States: IDLE, WAIT, ISSUE, CLR.
- IDLE:
  - req_ready=1.
  - On req_valid=1: latch req_mask, clear counter, go to WAIT.
- WAIT:
  - sat = ((flags_in & mask)==mask), evaluated every cycle.
  - sat=1: go to ISSUE.
  - Else, if TIMEOUT!=0 and counter==TIMEOUT-1: go to IDLE, timeout=1 for exactly the next cycle, no unset issued.
  - Else: counter+1.
  - sat has priority over timeout in the same cycle.
  - mask=0 gives sat=1, so ISSUE follows immediately.
- ISSUE:
  - go_valid=1, held until go_ready=1. Flags are not re-checked here; once sat they stay committed.
  - On go_valid&go_ready: go to CLR.
  - No timeout counting in ISSUE.
- CLR:
  - Exactly one cycle with unset_out=mask. unset_out is 0 in every other state.
  - Then go to IDLE.
- Latency:
  - Request accepted at cycle 0, flags already set: go_valid at cycle 2.
  - go handshake at cycle n: unset_out at n+1, flag registers clear at n+2, req_ready at n+2.
  - A new request therefore never sees stale flags.
- Flags outside the mask are never unset.
- A producer set pulse coinciding with the CLR cycle on a masked flag is dropped, because unset wins in the flag register. Producers must not set a flag before its consumer's go.
- Async reset mid-operation (any state): immediate return to reset values. Any pending unset is not issued, so flags remain as set.
- busy=1 in WAIT, ISSUE and CLR.
- timeout pulse coincides with IDLE, so req_ready=1 in the same cycle.

Test Plan:
- Reset then idle: rst low for 3 cycles, then high -> req_ready=1, busy=0, go_valid=0, unset_out=0000.
- Mask 0011, flags_in=0011 already set, req at cycle 0, go_ready=1 -> go_valid cycle 2, unset_out=0011 only at cycle 3, req_ready=1 at cycle 4.
- Mask 0101, flags_in=0001, bit 2 set at cycle 10, go_ready held low until cycle 15 -> go_valid from cycle 11 to 15 stable, unset_out=0101 at cycle 16, bits 1 and 3 never unset.
- TIMEOUT=5, mask 1000, flags_in=0000 -> return to IDLE with timeout=1 for one cycle 6 cycles after acceptance, unset_out stays 0000, then accept a new request.
- Flag becomes satisfied on the same cycle the counter reaches TIMEOUT-1 -> ISSUE taken, no timeout pulse. Also mask 0000 -> go_valid 2 cycles after acceptance, unset_out=0000.
- rst asserted during ISSUE with go_valid=1 -> go_valid, busy and unset_out drop immediately, flags_in unchanged, req_ready=1 after release.
